mul_ctrl: RTL

- Sequencing controller for the unsigned shift-add multiplier (`mul`) in the EXE stage.
- Decodes RV32M MUL/MULH/MULHSU/MULHU and converts signed operands to magnitudes.
- Drives the multiplier's req/flush handshake, then sign-corrects and selects the 32-bit result.
- Stalls the pipeline until the result is delivered.

---
 rtl/exe_pkg.sv | 19 +
 rtl/mul_sign_fix.sv | 37 +++
 rtl/mul_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - shared EXE-stage encodings for the multiply controller
package exe_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    MC_IDLE = 2'b00,
    MC_BUSY = 2'b01,
    MC_DONE = 2'b10
  } mc_state_e;

endpackage

// File: rtl/mul_sign_fix.sv
// rtl/mul_sign_fix.sv - operand magnitudes, result sign flag, product negate and half select
module mul_sign_fix
  import exe_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [1:0]        op_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  output logic [XLEN-1:0]   mag_a_o,
  output logic [XLEN-1:0]   mag_b_o,
  output logic              neg_o,
  output logic              hi_o,
  input  logic              res_neg_i,
  input  logic              res_hi_i,
  input  logic [2*XLEN-1:0] prod_i,
  output logic [XLEN-1:0]   res_o
);

  logic              s1, s2, neg_a, neg_b;
  logic [2*XLEN-1:0] prod_s;

  assign s1    = (op_i == MUL_OP_MULH) || (op_i == MUL_OP_MULHSU);
  assign s2    = (op_i == MUL_OP_MULH);
  assign neg_a = s1 & rs1_i[XLEN-1];
  assign neg_b = s2 & rs2_i[XLEN-1];

  // the most negative value negates to itself, which is its correct unsigned magnitude
  assign mag_a_o = neg_a ? ({XLEN{1'b0}} - rs1_i) : rs1_i;
  assign mag_b_o = neg_b ? ({XLEN{1'b0}} - rs2_i) : rs2_i;
  assign neg_o   = neg_a ^ neg_b;
  assign hi_o    = (op_i != MUL_OP_MUL);

  assign prod_s = res_neg_i ? ({(2*XLEN){1'b0}} - prod_i) : prod_i;
  assign res_o  = res_hi_i ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];

endmodule

// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - RV32M multiply sequencer around the shift-add multiplier; MUL_CTRL_PCACHE_EN adds a product cache
module mul_ctrl
  import exe_pkg::*;
#(
  parameter int XLEN = exe_pkg::XLEN_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [1:0]        op_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic [XLEN-1:0]   mul_a_o,
  output logic [XLEN-1:0]   mul_b_o,
  output logic              mul_req_o,
  output logic              mul_flush_o,
  input  logic              mul_ready_i,
  input  logic [2*XLEN-1:0] mul_result_i
);

  mc_state_e         state_q, state_d;
  logic              neg_r, hi_r;
  logic              neg_new, hi_new, res_neg, res_hi;
  logic [XLEN-1:0]   mag_a, mag_b, res;
  logic [2*XLEN-1:0] res_prod;
  logic              cache_hit, issue, capture;

`ifdef MUL_CTRL_PCACHE_EN
  logic              pc_valid;
  logic [XLEN-1:0]   pc_a, pc_b;
  logic [2*XLEN-1:0] pc_prod;

  assign cache_hit = pc_valid && (pc_a == mag_a) && (pc_b == mag_b);
  // in IDLE the result is built from the cached product with the new instruction's flags
  assign res_prod  = (state_q == MC_IDLE) ? pc_prod : mul_result_i;
`else
  assign cache_hit = 1'b0;
  assign res_prod  = mul_result_i;
`endif

  assign res_neg = (state_q == MC_IDLE) ? neg_new : neg_r;
  assign res_hi  = (state_q == MC_IDLE) ? hi_new : hi_r;

  mul_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op_i      (op_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .mag_a_o   (mag_a),
    .mag_b_o   (mag_b),
    .neg_o     (neg_new),
    .hi_o      (hi_new),
    .res_neg_i (res_neg),
    .res_hi_i  (res_hi),
    .prod_i    (res_prod),
    .res_o     (res)
  );

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    capture = 1'b0;
    if (flush_i) begin
      state_d = MC_IDLE;
    end else begin
      case (state_q)
        MC_IDLE: if (valid_i) begin
          issue   = 1'b1;
          capture = cache_hit;
          state_d = cache_hit ? MC_DONE : MC_BUSY;
        end
        MC_BUSY: if (mul_ready_i) begin
          capture = 1'b1;
          state_d = MC_DONE;
        end
        MC_DONE: state_d = MC_IDLE;
        default: state_d = MC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= MC_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_o    <= 1'b0;
      rd_data_o <= '0;
      mul_req_o <= 1'b0;
      mul_a_o   <= '0;
      mul_b_o   <= '0;
      neg_r     <= 1'b0;
      hi_r      <= 1'b0;
    end else begin
      mul_req_o <= (state_d == MC_BUSY);
      done_o    <= (state_d == MC_DONE);
      if (issue) begin
        mul_a_o <= mag_a;
        mul_b_o <= mag_b;
        neg_r   <= neg_new;
        hi_r    <= hi_new;
      end
      if (capture) rd_data_o <= res;
    end
  end

`ifdef MUL_CTRL_PCACHE_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_valid <= 1'b0;
      pc_a     <= '0;
      pc_b     <= '0;
      pc_prod  <= '0;
    end else if (flush_i && (state_q == MC_BUSY)) begin
      pc_valid <= 1'b0;
    end else if (capture && (state_q == MC_BUSY)) begin
      pc_valid <= 1'b1;
      pc_a     <= mul_a_o;
      pc_b     <= mul_b_o;
      pc_prod  <= mul_result_i;
    end
  end
`endif

  assign stall_o     = valid_i & (state_q != MC_DONE);
  assign mul_flush_o = flush_i;

  // the instruction must stay put while the multiplier works on it
  a_stable_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    ((state_q == MC_BUSY) && !flush_i) |->
      (valid_i && (mag_a == mul_a_o) && (mag_b == mul_b_o) && (neg_new == neg_r) && (hi_new == hi_r)));

endmodule
